// File: rtl/conv_pkg.sv
// Shared constants and state encoding for the 3x3 convolution MAC.
package conv_pkg;

    localparam int NUM_TAPS = 9;
    localparam int PIX_W    = 32;
    localparam int COEF_W   = 16;
    localparam int FRAC     = 8;
    localparam int ACC_W    = 32;

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        NORM,
        OUT
    } state_t;

    // Only the low byte of a tap carries the pixel; the rest is sideband.
    function automatic logic [7:0] tap_pixel(input logic [PIX_W-1:0] tap);
        return tap[7:0];
    endfunction

endpackage

// File: rtl/round_sat_u8.sv
// Round-half-up fixed-point normalisation of a signed accumulator,
// clamped to an unsigned 8-bit pixel.
module round_sat_u8 #(
    parameter int FRAC = 8
) (
    input  logic signed [31:0] acc,
    output logic        [7:0]  pix
);

    localparam logic signed [32:0] HALF = 33'(1) << (FRAC - 1);

    logic signed [32:0] biased;
    logic signed [32:0] shifted;

    // One guard bit so the rounding bias can never wrap a large positive sum.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        pix     = 8'd0;
        biased  = 33'(acc) + HALF;
        shifted = biased >>> FRAC;
        if (shifted < 0) begin
            pix = 8'd0;
        end else if (shifted > 33'sd255) begin
            pix = 8'hFF;
        end else begin
            pix = shifted[7:0];
        end
    end

endmodule

// File: rtl/conv3x3_mac.sv
// Sequential 3x3 convolution: one tap multiply-accumulate per cycle,
// then round/saturate to an 8-bit pixel held until the consumer takes it.
module conv3x3_mac
    import conv_pkg::*;
#(
    parameter int totalcycle = conv_pkg::NUM_TAPS,
    parameter int COEF_W     = conv_pkg::COEF_W,
    parameter int FRAC       = conv_pkg::FRAC
) (
    input  logic                          clk,
    input  logic                          reset_MAC,
    input  logic [totalcycle*PIX_W-1:0]   window,
    input  logic                          window_valid,
    output logic                          win_ready,
    input  logic                          coef_wr,
    input  logic [3:0]                    coef_addr,
    input  logic signed [COEF_W-1:0]      coef_data,
    output logic [31:0]                   result,
    output logic                          result_valid,
    input  logic                          out_ready,
    output logic                          busy
);

    localparam int KW       = (totalcycle > 1) ? $clog2(totalcycle) : 1;
    localparam int PROD_W   = COEF_W + 9;
    localparam int CENTER   = totalcycle / 2;
    localparam logic signed [COEF_W-1:0] COEF_ONE = COEF_W'(1 << FRAC);
    localparam logic [KW-1:0] K_LAST = KW'(totalcycle - 1);

    state_t                    state;
    logic [KW-1:0]             k;
    logic signed [ACC_W-1:0]   acc;
    logic [7:0]                pix_q [totalcycle];
    logic signed [COEF_W-1:0]  coef  [totalcycle];
    logic signed [PROD_W-1:0]  prod;
    logic [7:0]                sat_pix;
    logic                      capture;
    logic                      coef_we;

    assign capture = win_ready && window_valid;
    assign coef_we = (state == IDLE) && coef_wr && (int'(coef_addr) < totalcycle);

    // Zero-extended pixel times signed coefficient, both widened before the multiply.
    assign prod = PROD_W'($signed({1'b0, pix_q[k]})) * PROD_W'(coef[k]);

    // Coefficients come back to the identity kernel on reset.
    always_ff @(posedge clk) begin
        if (reset_MAC) begin
            for (int i = 0; i < totalcycle; i++) begin
                coef[i] <= (i == CENTER) ? COEF_ONE : '0;
            end
        end else if (coef_we) begin
            coef[coef_addr] <= coef_data;
        end
    end

    // NOTE: the window register is pure datapath and is only read after a capture, so it has no reset.
    always_ff @(posedge clk) begin
        if (capture) begin
            for (int i = 0; i < totalcycle; i++) begin
                pix_q[i] <= tap_pixel(window[i*PIX_W +: PIX_W]);
            end
        end
    end

    round_sat_u8 #(
        .FRAC (FRAC)
    ) u_round_sat (
        .acc (acc),
        .pix (sat_pix)
    );

    always_ff @(posedge clk) begin
        // NOTE: all sequential state uses non-blocking assignments so every register sees pre-edge values.
        if (reset_MAC) begin
            state        <= IDLE;
            acc          <= '0;
            k            <= '0;
            result       <= '0;
            result_valid <= 1'b0;
            busy         <= 1'b0;
            win_ready    <= 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    if (capture) begin
                        acc       <= '0;
                        k         <= '0;
                        state     <= MAC;
                        win_ready <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                MAC: begin
                    acc <= acc + ACC_W'(prod);
                    if (k == K_LAST) begin
                        k     <= '0;
                        state <= NORM;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                NORM: begin
                    result       <= {24'b0, sat_pix};
                    result_valid <= 1'b1;
                    state        <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        result       <= '0;
                        result_valid <= 1'b0;
                        state        <= IDLE;
                        win_ready    <= 1'b1;
                        busy         <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    win_ready <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv3x3_mac.sv
// Directed bench for conv3x3_mac: a vector table of kernels/windows plus
// hand-written sequences for backpressure, mid-operation reset and ignored writes.
module tb_conv3x3_mac;

    logic             clk = 1'b0;
    logic             reset_MAC;
    logic [9*32-1:0]  window;
    logic             window_valid;
    logic             win_ready;
    logic             coef_wr;
    logic [3:0]       coef_addr;
    logic [15:0]      coef_data;
    logic [31:0]      result;
    logic             result_valid;
    logic             out_ready;
    logic             busy;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [8:0][15:0] coef;
        logic [8:0][7:0]  tap;
        logic [7:0]       exp;
    } vec_t;

    localparam int NV = 7;
    vec_t vec [NV];

    conv3x3_mac dut (
        .clk          (clk),
        .reset_MAC    (reset_MAC),
        .window       (window),
        .window_valid (window_valid),
        .win_ready    (win_ready),
        .coef_wr      (coef_wr),
        .coef_addr    (coef_addr),
        .coef_data    (coef_data),
        .result       (result),
        .result_valid (result_valid),
        .out_ready    (out_ready),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Upper 24 bits of every tap are filled with junk; only the pixel byte should matter.
    function automatic logic [9*32-1:0] pack(input logic [8:0][7:0] taps);
        logic [9*32-1:0] w;
        logic [23:0]     junk;
        w = '0;
        for (int j = 0; j < 9; j++) begin
            junk = 24'($urandom);
            w[j*32 +: 32] = {junk, taps[j]};
        end
        return w;
    endfunction

    function automatic logic [8:0][7:0] fill_taps(input logic [7:0] other, input logic [7:0] center);
        logic [8:0][7:0] t;
        for (int j = 0; j < 9; j++) t[j] = other;
        t[4] = center;
        return t;
    endfunction

    task automatic do_reset();
        reset_MAC = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset_MAC = 1'b0;
    endtask

    task automatic write_coef(input logic [3:0] a, input logic [15:0] d);
        @(negedge clk);
        coef_wr   = 1'b1;
        coef_addr = a;
        coef_data = d;
        @(posedge clk);
        #1;
        coef_wr = 1'b0;
    endtask

    // Presents one window; optionally writes a coefficient on the same edge.
    task automatic capture_window(input logic [8:0][7:0] taps, input logic with_coef,
                                  input logic [3:0] a, input logic [15:0] d);
        @(negedge clk);
        window       = pack(taps);
        window_valid = 1'b1;
        coef_wr      = with_coef;
        coef_addr    = a;
        coef_data    = d;
        @(posedge clk);
        #1;
        window_valid = 1'b0;
        coef_wr      = 1'b0;
    endtask

    // Counts edges after the capture edge until result_valid; -1 if it never comes.
    task automatic wait_valid(output int lat);
        lat = -1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            if (result_valid) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic handshake_check(input string tag);
        @(posedge clk);
        #1;
        check({tag, " valid dropped"}, int'(result_valid), 0);
        check({tag, " result cleared"}, int'(result), 0);
        check({tag, " win_ready back"}, int'(win_ready), 1);
    endtask

    initial begin
        int lat;
        int seen;
        logic [8:0][7:0] t;

        reset_MAC    = 1'b0;
        window       = '0;
        window_valid = 1'b0;
        coef_wr      = 1'b0;
        coef_addr    = '0;
        coef_data    = '0;
        out_ready    = 1'b1;

        // Vector table: coefficients in Q8.8, expected pixels computed by hand.
        for (int i = 0; i < NV; i++) begin
            vec[i].coef = '0;
            vec[i].tap  = '0;
        end
        vec[0].coef[4] = 16'h0100;
        for (int j = 0; j < 9; j++) vec[0].tap[j] = 8'($urandom_range(0, 255));
        vec[0].tap[4] = 8'd200;
        vec[0].exp    = 8'd200;
        for (int j = 0; j < 9; j++) begin
            vec[1].coef[j] = 16'h0020;
            vec[1].tap[j]  = 8'd100;
        end
        vec[1].exp = 8'd113;                      // 28800 -> (28800+128)>>8
        vec[2].coef[4] = 16'h0200; vec[2].tap = fill_taps(8'd9, 8'd200); vec[2].exp = 8'd255;
        vec[3].coef[4] = 16'hFF00; vec[3].tap = fill_taps(8'd9, 8'd50);  vec[3].exp = 8'd0;
        vec[4].coef[0] = 16'h0080; vec[4].coef[8] = 16'h0040;
        vec[4].tap[0]  = 8'd100;   vec[4].tap[8]  = 8'd40;  vec[4].exp = 8'd60;   // 12800+2560
        vec[5].coef[4] = 16'h0180; vec[5].tap[4]  = 8'd3;   vec[5].exp = 8'd5;    // 4.5 rounds up
        vec[6].coef[3] = 16'hFF80; vec[6].coef[4] = 16'h0100;
        vec[6].tap[3]  = 8'd20;    vec[6].tap[4]  = 8'd30;  vec[6].exp = 8'd20;   // -2560+7680

        do_reset();
        check("reset result", int'(result), 0);
        check("reset result_valid", int'(result_valid), 0);
        check("reset win_ready", int'(win_ready), 1);
        check("reset busy", int'(busy), 0);

        // Table: taps 0..7 written ahead, tap 8 written on the capture edge itself.
        for (int i = 0; i < NV; i++) begin
            for (int a = 0; a < 8; a++) write_coef(4'(a), vec[i].coef[a]);
            check($sformatf("vec%0d win_ready idle", i), int'(win_ready), 1);
            capture_window(vec[i].tap, 1'b1, 4'd8, vec[i].coef[8]);
            check($sformatf("vec%0d busy", i), int'(busy), 1);
            wait_valid(lat);
            check($sformatf("vec%0d latency", i), lat, 10);
            check($sformatf("vec%0d result", i), int'(result), int'(vec[i].exp));
            handshake_check($sformatf("vec%0d", i));
        end

        // Backpressure: result held, new windows ignored, single-cycle release.
        do_reset();
        out_ready = 1'b0;
        capture_window(fill_taps(8'd5, 8'd77), 1'b0, 4'd0, 16'h0000);
        wait_valid(lat);
        check("bp latency", lat, 10);
        check("bp result", int'(result), 77);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            window       = pack(fill_taps(8'd3, 8'd1));
            window_valid = 1'b1;
            @(posedge clk);
            #1;
            check($sformatf("bp hold%0d result", c), int'(result), 77);
            check($sformatf("bp hold%0d valid", c), int'(result_valid), 1);
            check($sformatf("bp hold%0d win_ready", c), int'(win_ready), 0);
        end
        @(negedge clk);
        window_valid = 1'b0;
        out_ready    = 1'b1;
        handshake_check("bp release");
        seen = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (busy || result_valid) seen++;
        end
        check("bp nothing queued", seen, 0);

        // Reset four taps into a MAC: aborts, and restores the identity kernel.
        write_coef(4'd4, 16'h0200);
        capture_window(fill_taps(8'd7, 8'd99), 1'b0, 4'd0, 16'h0000);
        repeat (4) @(posedge clk);
        #1;
        reset_MAC = 1'b1;
        @(posedge clk);
        #1;
        reset_MAC = 1'b0;
        check("abort result_valid", int'(result_valid), 0);
        check("abort win_ready", int'(win_ready), 1);
        check("abort busy", int'(busy), 0);
        seen = 0;
        repeat (15) begin
            @(posedge clk);
            #1;
            if (result_valid) seen++;
        end
        check("abort no result", seen, 0);
        capture_window(fill_taps(8'd7, 8'd99), 1'b0, 4'd0, 16'h0000);
        wait_valid(lat);
        check("abort then identity", int'(result), 99);
        handshake_check("abort");

        // Writes while busy are dropped.
        capture_window(fill_taps(8'd20, 8'd50), 1'b0, 4'd0, 16'h0000);
        coef_wr   = 1'b1;
        coef_addr = 4'd4;
        coef_data = 16'h0300;
        wait_valid(lat);
        coef_wr = 1'b0;
        check("busy write ignored", int'(result), 50);
        handshake_check("busy write");

        // Out-of-range addresses are dropped.
        for (int a = 9; a < 16; a++) write_coef(4'(a), 16'h7FFF);
        t = fill_taps(8'd20, 8'd60);
        capture_window(t, 1'b0, 4'd0, 16'h0000);
        wait_valid(lat);
        check("oob write latency", lat, 10);
        check("oob write ignored", int'(result), 60);
        handshake_check("oob write");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/conv3x3_mac.md
CONV3X3_MAC -- requirements
Module: conv3x3_mac

Interface
REQ-001 SHALL have parameter totalcycle, default 9, giving the number of taps per window.
REQ-002 SHALL have parameter COEF_W, default 16, giving the signed coefficient width.
REQ-003 SHALL have parameter FRAC, default 8, giving the number of coefficient fraction bits (Q8.8).
REQ-004 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port reset_MAC  input  1  synchronous, active-high reset.
REQ-006 SHALL have port window  input  totalcycle*32  packed taps; tap k = window[k*32 +: 32].
REQ-007 SHALL have port window_valid  input  1  window present.
REQ-008 SHALL have port win_ready  output  1  block can accept a window.
REQ-009 SHALL have port coef_wr  input  1  coefficient write strobe.
REQ-010 SHALL have port coef_addr  input  4  tap index to write.
REQ-011 SHALL have port coef_data  input  COEF_W  signed coefficient.
REQ-012 SHALL have port result  output  32  {24'b0, 8-bit saturated pixel}.
REQ-013 SHALL have port result_valid  output  1  result held for consumer.
REQ-014 SHALL have port out_ready  input  1  consumer accepts result.
REQ-015 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-016 SHALL use only pixel[7:0] (unsigned) of each tap; bits [31:8] are ignored.
REQ-017 SHALL implement states IDLE, MAC, NORM and OUT; win_ready is high only in IDLE.
REQ-018 SHALL, in IDLE, capture window into an internal register, clear the accumulator, set k=0 and go to MAC on an edge where window_valid && win_ready.
REQ-019 SHALL, in MAC, add tap[k] * coef[k] (8u x 16s, 25-bit signed product) to a 32-bit signed accumulator each cycle, for k = 0..totalcycle-1, and go to NORM after k = totalcycle-1.
REQ-020 SHALL, in NORM, compute (acc + 2^(FRAC-1)) >>> FRAC (arithmetic shift), clamp the value to 0..255, register it into result, and go to OUT.
REQ-021 SHALL, in OUT, hold result_valid = 1 with result stable until out_ready = 1, then go to IDLE on the next edge.
REQ-022 SHALL assert result_valid exactly totalcycle+1 cycles after the capture edge when out_ready is held high (10 cycles at the default).
REQ-023 SHALL ignore window_valid outside IDLE; no second window is queued.
REQ-024 SHALL perform a coefficient write only in IDLE with coef_addr < totalcycle; writes while busy, or with coef_addr >= totalcycle, SHALL leave all coefficients unchanged.
REQ-025 SHALL perform both operations when a coefficient write and a window capture occur on the same IDLE edge, and the MAC that follows SHALL use the newly written coefficient.
REQ-026 SHALL return result to 0 and drop result_valid on the edge on which the OUT handshake completes.

Reset
REQ-027 SHALL, while reset_MAC is high at a clock edge, force state IDLE, accumulator 0, k 0, result 0, result_valid 0, busy 0 and win_ready 1 after that edge.
REQ-028 SHALL restore the coefficients on reset to the identity kernel: coef[4] = 0x0100, all others 0.
REQ-029 SHALL abort any operation (MAC, NORM or OUT) when reset is applied mid-operation, with no result produced.

Structure
REQ-030 SHALL take the constants NUM_TAPS=9, PIX_W=32, COEF_W=16, FRAC=8 and the state encoding from shared package conv_pkg.
REQ-031 SHALL implement rounding and clamping in one sub-module, round_sat_u8 (32-bit signed in, 8-bit unsigned out, FRAC parameter).

Verification
REQ-032 SHALL verify: after reset, a window with tap4=200 and other taps 0..255 random -> result 200, result_valid 10 cycles after capture.
REQ-033 SHALL verify: all coefficients 0x0020 and all taps 100 -> acc 28800 -> result 113.
REQ-034 SHALL verify: coef4=0x0200 with tap4=200 -> 255 (saturate high), and coef4=0xFF00 with tap4=50 -> 0 (saturate low).
REQ-035 SHALL verify: out_ready low for 5 cycles in OUT -> result stable, win_ready 0, and an extra window_valid is ignored; an out_ready pulse -> IDLE next cycle.
REQ-036 SHALL verify: reset asserted at k=4 -> result_valid 0 and win_ready 1 after the edge, then an identity-kernel window returns tap4.
REQ-037 SHALL verify: coef_wr while busy, and coef_addr=9..15 in IDLE -> the next result is unchanged from the identity kernel.
